// File: rtl/axi_pkg.sv
// Shared AXI types: burst encodings, response codes and the read-slave FSM states.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI beat-address stepper (FIXED/INCR/WRAP); shared by read and write slaves.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int SIZE_W = 3
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [SIZE_W-1:0] size_i,
  input  burst_e            burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_len;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_base;
  logic [ADDR_W-1:0] wrap_addr;

  always_comb begin
    step      = ADDR_W'(1) << size_i;
    wrap_len  = (ADDR_W'(len_i) + ADDR_W'(1)) << size_i;
    // Aligning before adding makes an unaligned INCR start snap to the grid after beat 0.
    incr_addr = (addr_i & ~(step - ADDR_W'(1))) + step;
    wrap_base = addr_i & ~(wrap_len - ADDR_W'(1));
    wrap_addr = wrap_base | ((addr_i + step) & (wrap_len - ADDR_W'(1)));

    next_addr_o = incr_addr;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = wrap_addr;
      default:     next_addr_o = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi_rd_slave_mem.sv
// AXI4 read-only slave memory: one burst at a time, R beats from a word array,
// OKAY/SLVERR responses, plus a backdoor write port for preloading.
module axi_rd_slave_mem
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 8,
  parameter int SIZE_W    = 3,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [ADDR_W-1:0]            araddr,
  input  logic [LEN_W-1:0]             arlen,
  input  logic [SIZE_W-1:0]            arsize,
  input  logic [1:0]                   arburst,
  input  logic                         arvalid,
  output logic                         arready,
  output logic                         rvalid,
  input  logic                         rready,
  output logic                         rlast,
  output logic [1:0]                   rresp,
  output logic [DATA_W-1:0]            rdata,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
  input  logic [DATA_W-1:0]            mem_wdata
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  state_e            state_q, state_d;
  logic              arready_q, arready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [SIZE_W-1:0] size_q, size_d;
  burst_e            burst_q, burst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];

  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] word_idx;
  logic              in_range;
  logic              beat_last;
  logic              beat_err;
  logic              ar_hs;
  logic              r_hs;

  function automatic logic burst_err(
    input logic [ADDR_W-1:0] addr,
    input logic [LEN_W-1:0]  len,
    input logic [SIZE_W-1:0] size,
    input burst_e            burst
  );
    logic              wrap_len_ok;
    logic [ADDR_W-1:0] align_mask;
    wrap_len_ok = (len == LEN_W'(1)) || (len == LEN_W'(3)) ||
                  (len == LEN_W'(7)) || (len == LEN_W'(15));
    align_mask  = (ADDR_W'(1) << size) - ADDR_W'(1);
    burst_err   = (size > SIZE_W'(OFF_W)) || (burst == BURST_RSVD) ||
                  ((burst == BURST_WRAP) && (!wrap_len_ok || ((addr & align_mask) != '0)));
  endfunction

  axi_burst_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W),
    .SIZE_W (SIZE_W)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .len_i       (len_q),
    .size_i      (size_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr)
  );

  assign arready   = arready_q;
  assign rvalid    = (state_q == ST_BURST);
  assign ar_hs     = arvalid & arready_q;
  assign r_hs      = rvalid & rready;
  assign beat_last = (cnt_q == len_q);
  assign word_idx  = addr_q >> OFF_W;
  assign in_range  = (word_idx < ADDR_W'(MEM_DEPTH));
  assign beat_err  = err_q | ~in_range;

  assign rlast = rvalid & beat_last;
  assign rresp = (rvalid && beat_err) ? RESP_SLVERR : RESP_OKAY;
  // Combinational read so a beat address change shows its word in the same cycle.
  assign rdata = (rvalid && !beat_err) ? mem_q[IDX_W'(word_idx)] : '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ar_hs) begin
          state_d = ST_BURST;
          addr_d  = araddr;
          len_d   = arlen;
          size_d  = arsize;
          burst_d = burst_e'(arburst);
          cnt_d   = '0;
          err_d   = burst_err(araddr, arlen, arsize, burst_e'(arburst));
        end
      end
      ST_BURST: begin
        if (r_hs) begin
          if (beat_last) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d  = cnt_q + LEN_W'(1);
            addr_d = next_addr;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    arready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= BURST_FIXED;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Array contents survive reset; the backdoor may write in any state.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule
